mul_int: RTL and testbench
==========================

Name: mul_int

Overview:
- Iterative unsigned shift-add multiplier, one multiplier bit per cycle. It is the inverse-operation companion to the team's iterative divider, div_int.
- Uses the same start/busy/valid handshake as div_int, so the CPU ALU sequencer drives both units identically.
- Produces a full double-width product, plus zero and overflow flags for the CPU status register.

Parameters:
- WIDTH, 9, operand width in bits; product is 2*WIDTH bits; WIDTH >= 2.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  load operands and begin a multiply; sampled every rising edge.
- x  input  WIDTH  multiplicand; sampled only on a start edge.
- y  input  WIDTH  multiplier; sampled only on a start edge.
- busy  output  1  calculation in progress.
- valid  output  1  p, zero and ovf hold a valid result.
- p  output  2*WIDTH  product x*y.
- zero  output  1  product equals 0.
- ovf  output  1  product does not fit in WIDTH bits (p[2*WIDTH-1:WIDTH] != 0).

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - rst_n low immediately forces busy=0, valid=0, p=0, zero=0, ovf=0; internal counter and registers are cleared.
  - Reset asserted mid-operation aborts the operation. No result is produced.
- Internal state:
  - mcand register (WIDTH bits).
  - P register (2*WIDTH bits) holding {acc, remaining multiplier bits}.
  - Iteration counter i, $clog2(WIDTH) bits.
- Start edge (start=1), whether or not busy:
  - valid<=0, i<=0, mcand<=x, P<={WIDTH zeros, y}, busy<=1.
  - A start while busy abandons the current operation and restarts with the new operands. p, zero and ovf keep their old values until overwritten.
- Busy edge (start=0, busy=1), one step:
  - sum = {1'b0, P[2W-1:W]} + (P[0] ? mcand : 0), computed WIDTH+1 bits wide.
  - P_next = {sum, P[W-1:1]}, i.e. a logical right shift of {carry, acc, mplier}.
- Finish: on the busy edge where i==WIDTH-1:
  - busy<=0, valid<=1, p<=P_next, zero<=(P_next==0), ovf<=(P_next[2W-1:W]!=0).
  - Otherwise i<=i+1 and P<=P_next.
- Latency: valid rises exactly WIDTH rising edges after the start edge. busy is high for exactly WIDTH cycles.
- Hold: valid, p, zero and ovf hold until the next start edge or reset. valid drops on the start edge itself.
- Idle: start=0 and busy=0 leaves all state unchanged.
- Arithmetic: no truncation at any step; the sum carry enters P bit 2W-1 before the shift. Maximum product is (2^W-1)^2, which fits in 2W bits.
- x and y may change freely while busy; they are not sampled.
- start held high for multiple cycles restarts every cycle. busy stays 1 and valid stays 0 until start deasserts, then completes WIDTH edges later.

Optional Feature:
- Macro MUL_ZERO_BYPASS_EN.
- Defined: on a start edge with x==0 or y==0:
  - busy<=0, valid<=1, p<=0, zero<=1, ovf<=0, all on that same edge.
  - valid is visible one edge after start; busy never asserts.
- Undefined: zero operands take the normal WIDTH-cycle path and yield the same final values after WIDTH edges.

Test Plan:
- WIDTH=9, x=25, y=17, one-cycle start -> busy high 9 cycles; valid on 9th edge after start; p=425, zero=0, ovf=0.
- x=511, y=511 -> p=261121 (0x3FC01), ovf=1, zero=0. x=300, y=2 -> p=600, ovf=1.
- x=7, y=0:
  - Bypass defined -> valid one edge after start, busy never 1, p=0, zero=1.
  - Bypass undefined -> valid after 9 edges, p=0, zero=1, ovf=0.
- Start x=100, y=3, then at edge 4 start x=12, y=12 -> valid stays 0 until 9 edges after the second start; p=144, ovf=0. The 300 result is never reported.
- Start x=50, y=50, drop rst_n at edge 5 -> busy=0, valid=0, p=0 immediately. After release, start x=3, y=5 -> p=15 after 9 edges.
- Back-to-back: start on the edge immediately after valid rises, x=511, y=1 -> valid falls on that edge; p=511, ovf=0 after 9 more edges.

Source files
------------

// File: rtl/mul_int.sv
// mul_int: iterative unsigned shift-add multiplier, one multiplier bit per cycle.
// Shares the start/busy/valid handshake of div_int. Produces a full 2*WIDTH-bit
// product with zero and overflow flags.
// Optional feature: define MUL_ZERO_BYPASS_EN to finish a multiply with a zero
// operand on the start edge itself instead of running WIDTH steps.
module mul_int #(
    parameter int unsigned WIDTH = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    output logic               busy,
    output logic               valid,
    output logic [2*WIDTH-1:0] p,
    output logic               zero,
    output logic               ovf
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0]    mcand, mcand_n;
    logic [PW-1:0]       prod, prod_n;
    logic                busy_n;
    logic                valid_n;
    logic [PW-1:0]       p_n;
    logic                zero_n;
    logic                ovf_n;
    logic [WIDTH:0]      sum;
    logic [PW-1:0]       prod_step;

    // One shift-add step: add multiplicand into the upper half when the
    // current multiplier bit is set, then shift {carry, acc, mplier} right.
    always_comb begin
        sum       = {1'b0, prod[PW-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : (WIDTH+1)'(0));
        prod_step = {sum, prod[WIDTH-1:1]};
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        mcand_n = mcand;
        prod_n  = prod;
        valid_n = valid;
        p_n     = p;
        zero_n  = zero;
        ovf_n   = ovf;

        if (start) begin
            // A start always (re)loads operands, abandoning any running multiply.
            state_n = S_BUSY;
            cnt_n   = '0;
            mcand_n = x;
            prod_n  = {WIDTH'(0), y};
            valid_n = 1'b0;
`ifdef MUL_ZERO_BYPASS_EN
            if (x == '0 || y == '0) begin
                state_n = S_IDLE;
                valid_n = 1'b1;
                p_n     = '0;
                zero_n  = 1'b1;
                ovf_n   = 1'b0;
            end
`endif
        end else if (state == S_BUSY) begin
            if (cnt == LAST) begin
                state_n = S_IDLE;
                valid_n = 1'b1;
                p_n     = prod_step;
                zero_n  = (prod_step == '0);
                ovf_n   = (prod_step[PW-1:WIDTH] != '0);
            end else begin
                cnt_n   = cnt + CNT_W'(1);
                prod_n  = prod_step;
            end
        end

        busy_n = (state_n == S_BUSY);
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            mcand <= '0;
            prod  <= '0;
            busy  <= 1'b0;
            valid <= 1'b0;
            p     <= '0;
            zero  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            mcand <= mcand_n;
            prod  <= prod_n;
            busy  <= busy_n;
            valid <= valid_n;
            p     <= p_n;
            zero  <= zero_n;
            ovf   <= ovf_n;
        end
    end

endmodule

// File: tb/tb_mul_int.sv
// tb_mul_int: directed plus randomized checks of mul_int against x*y arithmetic.
module tb_mul_int;

    localparam int unsigned W    = 9;
    localparam int unsigned MASK = (1 << W) - 1;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic           busy;
    logic           valid;
    logic [2*W-1:0] p;
    logic           zero;
    logic           ovf;

    int n_checks = 0;
    int n_fail   = 0;

    mul_int #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .x     (x),
        .y     (y),
        .busy  (busy),
        .valid (valid),
        .p     (p),
        .zero  (zero),
        .ovf   (ovf)
    );

    // 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected result flags derived from plain arithmetic
    task automatic chk_result(input string tag, input int unsigned a, input int unsigned b);
        int unsigned e;
        e = a * b;
        chk({tag, ".valid"}, 32'(valid), 32'd1);
        chk({tag, ".busy"},  32'(busy),  32'd0);
        chk({tag, ".p"},     32'(p),     e);
        chk({tag, ".zero"},  32'(zero),  (e == 0) ? 32'd1 : 32'd0);
        chk({tag, ".ovf"},   32'(ovf),   (e > MASK) ? 32'd1 : 32'd0);
    endtask

    // Issue a one-cycle start and follow it to completion; operands are
    // scrambled while busy to show they are not resampled.
    task automatic run_mul(input string tag, input int unsigned a, input int unsigned b);
        bit bypass;
        bypass = 1'b0;
`ifdef MUL_ZERO_BYPASS_EN
        bypass = (a == 0) || (b == 0);
`endif
        x = W'(a);
        y = W'(b);
        start = 1'b1;
        tick();
        start = 1'b0;
        if (bypass) begin
            chk_result({tag, ".byp"}, a, b);
        end else begin
            for (int k = 1; k < int'(W); k++) begin
                chk({tag, ".busy_run"},  32'(busy),  32'd1);
                chk({tag, ".valid_run"}, 32'(valid), 32'd0);
                x = W'($urandom);
                y = W'($urandom);
                tick();
            end
            chk({tag, ".busy_last"}, 32'(busy), 32'd1);
            tick();
            chk_result(tag, a, b);
        end
    endtask

    initial begin
        int unsigned a, b, old_p;
        rst_n = 1'b0;
        start = 1'b0;
        x     = '0;
        y     = '0;
        tick();
        tick();
        chk("rst.busy",  32'(busy),  32'd0);
        chk("rst.valid", 32'(valid), 32'd0);
        chk("rst.p",     32'(p),     32'd0);
        chk("rst.zero",  32'(zero),  32'd0);
        chk("rst.ovf",   32'(ovf),   32'd0);
        rst_n = 1'b1;
        tick();

        // Directed products
        run_mul("m25x17",   25,  17);
        // Result holds while idle
        x = W'(1);
        y = W'(1);
        tick();
        tick();
        chk_result("hold", 25, 17);
        run_mul("m511x511", 511, 511);
        run_mul("m300x2",   300, 2);
        run_mul("m7x0",     7,   0);
        run_mul("m0x9",     0,   9);
        run_mul("m1x1",     1,   1);

        // Restart while busy: first operation must never report
        old_p = 32'(p);
        x = W'(100);
        y = W'(3);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k < 4; k++) begin
            chk("restart.valid_a", 32'(valid), 32'd0);
            tick();
        end
        chk("restart.p_held", 32'(p), old_p);
        run_mul("restart", 12, 12);

        // Start held high several cycles: last operands win
        x = W'(33);
        y = W'(44);
        start = 1'b1;
        tick();
        chk("hold_start.busy", 32'(busy), 32'd1);
        x = W'(55);
        y = W'(66);
        tick();
        chk("hold_start.valid", 32'(valid), 32'd0);
        run_mul("held_start", 200, 150);

        // Reset mid-operation
        x = W'(50);
        y = W'(50);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k < 5; k++) tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst.busy",  32'(busy),  32'd0);
        chk("mid_rst.valid", 32'(valid), 32'd0);
        chk("mid_rst.p",     32'(p),     32'd0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("mid_rst.no_valid", 32'(valid), 32'd0);
        end
        run_mul("after_rst", 3, 5);

        // Back-to-back: start on the edge right after valid rises
        old_p = 32'(p);
        x = W'(511);
        y = W'(1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b.valid_drop", 32'(valid), 32'd0);
        chk("b2b.busy",       32'(busy),  32'd1);
        chk("b2b.p_held",     32'(p),     old_p);
        for (int k = 1; k < int'(W); k++) tick();
        chk("b2b.busy_last", 32'(busy), 32'd1);
        tick();
        chk_result("b2b", 511, 1);

        // Randomized operands with a sprinkling of zeros and extremes
        for (int t = 0; t < 24; t++) begin
            a = $urandom_range(0, MASK);
            b = $urandom_range(0, MASK);
            if (t % 8 == 3) a = 0;
            if (t % 8 == 5) b = MASK;
            run_mul($sformatf("rnd%0d", t), a, b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time guard
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
